adau_cfg_sequencer: RTL and testbench

- Walks a fixed table of ADAU1761 register operations after reset and issues them as I2C write transactions through a byte-level I2C master.
- Handles NACK retries, timed delays (PLL lock settle) and completion/error reporting.
- Sits between the codec bring-up logic and the I2C byte engine that drives adau1761_cclk/adau1761_cout.
- The I2S controller is held off until done=1.

---
 rtl/adau_cfg_pkg.sv | 70 +++++++
 rtl/adau_cfg_rom.sv | 29 ++
 rtl/adau_cfg_sequencer.sv | 166 ++++++++++++++++
 tb/tb_adau_cfg_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adau_cfg_pkg.sv
// rtl/adau_cfg_pkg.sv - shared types, register addresses and frame helper for the ADAU1761 config sequencer
package adau_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_DELAY = 2'd1,
        OP_END   = 2'd2
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_BYTE,
        ST_WAIT_RSP,
        ST_DELAY,
        ST_BACKOFF,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [7:0] data;
    } cmd_byte_t;

    localparam logic [7:0]  ADAU_WR_ADDR     = 8'h76;

    localparam logic [15:0] REG_CLK_CTRL     = 16'h4000;
    localparam logic [15:0] REG_PLL_CTRL     = 16'h4002;
    localparam logic [15:0] REG_SERIAL_PORT0 = 16'h4015;
    localparam logic [15:0] REG_ADC_CTRL     = 16'h4019;
    localparam logic [15:0] REG_PLAY_MIX_L0  = 16'h401C;
    localparam logic [15:0] REG_PLAY_MIX_R0  = 16'h401E;
    localparam logic [15:0] REG_PLAY_POWER   = 16'h4029;
    localparam logic [15:0] REG_DAC_CTRL     = 16'h402A;
    localparam logic [15:0] REG_SERIAL_ROUTE = 16'h40F2;
    localparam logic [15:0] REG_CLK_EN0      = 16'h40F9;
    localparam logic [15:0] REG_CLK_EN1      = 16'h40FA;

    function automatic cfg_entry_t cfg_write(input logic [15:0] addr, input logic [7:0] data);
        cfg_write = '{op: OP_WRITE, addr: addr, data: data};
    endfunction

    function automatic cfg_entry_t cfg_delay(input logic [7:0] count);
        cfg_delay = '{op: OP_DELAY, addr: 16'h0000, data: count};
    endfunction

    function automatic cfg_entry_t cfg_end();
        cfg_end = '{op: OP_END, addr: 16'h0000, data: 8'h00};
    endfunction

    // One register write is a four-byte frame: device address, address high, address low, data.
    function automatic cmd_byte_t frame_byte(input logic [6:0] dev, input logic [1:0] bc,
                                             input cfg_entry_t e);
        case (bc)
            2'd0:    frame_byte = '{start: 1'b1, stop: 1'b0, data: {dev, 1'b0}};
            2'd1:    frame_byte = '{start: 1'b0, stop: 1'b0, data: e.addr[15:8]};
            2'd2:    frame_byte = '{start: 1'b0, stop: 1'b0, data: e.addr[7:0]};
            default: frame_byte = '{start: 1'b0, stop: 1'b1, data: e.data};
        endcase
    endfunction

endpackage

// File: rtl/adau_cfg_rom.sv
// rtl/adau_cfg_rom.sv - ADAU1761 bring-up register table, combinational read
module adau_cfg_rom
    import adau_cfg_pkg::*;
(
    input  logic [4:0] idx,
    output cfg_entry_t entry
);

    // The PLL needs time to lock before the codec clocks are switched on.
    always_comb begin
        entry = cfg_end();
        case (idx)
            5'd0:    entry = cfg_write(REG_CLK_CTRL,     8'h0F);
            5'd1:    entry = cfg_write(REG_PLL_CTRL,     8'h01);
            5'd2:    entry = cfg_delay(8'd10);
            5'd3:    entry = cfg_write(REG_SERIAL_PORT0, 8'h00);
            5'd4:    entry = cfg_write(REG_ADC_CTRL,     8'h03);
            5'd5:    entry = cfg_write(REG_PLAY_MIX_L0,  8'h21);
            5'd6:    entry = cfg_write(REG_PLAY_MIX_R0,  8'h41);
            5'd7:    entry = cfg_write(REG_PLAY_POWER,   8'h03);
            5'd8:    entry = cfg_write(REG_DAC_CTRL,     8'h03);
            5'd9:    entry = cfg_write(REG_SERIAL_ROUTE, 8'h01);
            5'd10:   entry = cfg_write(REG_CLK_EN0,      8'h7F);
            5'd11:   entry = cfg_write(REG_CLK_EN1,      8'h03);
            default: entry = cfg_end();
        endcase
    end

endmodule

// File: rtl/adau_cfg_sequencer.sv
// rtl/adau_cfg_sequencer.sv - walks the ADAU1761 config table and issues I2C write frames
module adau_cfg_sequencer
    import adau_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = ADAU_WR_ADDR[7:1],
    parameter int         NUM_ENTRIES = 32,
    parameter int         DELAY_UNIT  = 1000,
    parameter int         MAX_RETRY   = 3,
    parameter int         BACKOFF_CYC = 256,
    parameter bit         AUTO_START  = 1'b1
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_data,
    output logic       cmd_start,
    output logic       cmd_stop,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] err_index
);

    localparam int CNT_MAX = (255 * DELAY_UNIT > BACKOFF_CYC) ? 255 * DELAY_UNIT : BACKOFF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    state_t               state;
    logic [5:0]           idx;
    logic [1:0]           bc;
    logic [RETRY_W-1:0]   retry;
    logic [CNT_W-1:0]     cnt;
    logic                 auto_go;
    cfg_entry_t           entry;
    cmd_byte_t            nb;

    adau_cfg_rom u_rom (
        .idx   (idx[4:0]),
        .entry (entry)
    );

    // Next byte to present: the following frame byte after an ACK, otherwise the frame head.
    always_comb begin
        nb = frame_byte(DEV_ADDR, (state == ST_WAIT_RSP) ? bc + 2'd1 : 2'd0, entry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            bc        <= '0;
            retry     <= '0;
            cnt       <= '0;
            auto_go   <= AUTO_START;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            cmd_start <= 1'b0;
            cmd_stop  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start || (state == ST_IDLE && auto_go)) begin
                        auto_go   <= 1'b0;
                        state     <= ST_FETCH;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        idx       <= '0;
                        retry     <= '0;
                    end
                end

                ST_FETCH: begin
                    if (idx == 6'(NUM_ENTRIES) || !(entry.op == OP_WRITE || entry.op == OP_DELAY)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (entry.op == OP_DELAY) begin
                        cnt   <= CNT_W'(int'(entry.data) * DELAY_UNIT);
                        state <= ST_DELAY;
                    end else begin
                        bc        <= 2'd0;
                        cmd_valid <= 1'b1;
                        cmd_data  <= nb.data;
                        cmd_start <= nb.start;
                        cmd_stop  <= nb.stop;
                        state     <= ST_BYTE;
                    end
                end

                ST_BYTE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_start <= 1'b0;
                        cmd_stop  <= 1'b0;
                        state     <= ST_WAIT_RSP;
                    end
                end

                // On NACK the master closes the frame itself; only the retry policy lives here.
                ST_WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (!rsp_nack) begin
                            if (bc != 2'd3) begin
                                bc        <= bc + 2'd1;
                                cmd_valid <= 1'b1;
                                cmd_data  <= nb.data;
                                cmd_start <= nb.start;
                                cmd_stop  <= nb.stop;
                                state     <= ST_BYTE;
                            end else begin
                                idx   <= idx + 6'd1;
                                retry <= '0;
                                state <= ST_FETCH;
                            end
                        end else if (retry != RETRY_W'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            cnt   <= CNT_W'(BACKOFF_CYC);
                            state <= ST_BACKOFF;
                        end else begin
                            err_index <= idx[4:0];
                            error     <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_ERROR;
                        end
                    end
                end

                // A zero count still spends one cycle here.
                ST_DELAY: begin
                    if (cnt <= CNT_W'(1)) begin
                        idx   <= idx + 6'd1;
                        state <= ST_FETCH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_BACKOFF: begin
                    if (cnt <= CNT_W'(1)) begin
                        bc        <= 2'd0;
                        cmd_valid <= 1'b1;
                        cmd_data  <= nb.data;
                        cmd_start <= nb.start;
                        cmd_stop  <= nb.stop;
                        state     <= ST_BYTE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adau_cfg_sequencer.sv
// tb/tb_adau_cfg_sequencer.sv - self-checking bench for adau_cfg_sequencer
module tb_adau_cfg_sequencer;

    localparam int DU     = 10;
    localparam int BO     = 256;
    localparam int MR     = 3;
    localparam int NE     = 32;
    localparam int NTBL   = 13;
    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_n, start, cmd_ready, rsp_valid, rsp_nack;
    logic       cmd_valid, cmd_start, cmd_stop, busy, done, error;
    logic [7:0] cmd_data;
    logic [4:0] err_index;

    always #5 clk = ~clk;

    adau_cfg_sequencer #(
        .DEV_ADDR    (7'h3B),
        .NUM_ENTRIES (NE),
        .DELAY_UNIT  (DU),
        .MAX_RETRY   (MR),
        .BACKOFF_CYC (BO),
        .AUTO_START  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    // Intended init table: op 0 = write, 1 = delay, 2 = end; entries past the table read as end.
    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [7:0]  data;
    } tent_t;

    typedef struct {
        logic [7:0] data;
        logic       st;
        logic       sp;
        logic       nack;
        int         gap;
        int         entry;
    } xfer_t;

    typedef struct {
        int mode;
        int via_start;
        int abort_entry;
        int exp_done;
        int exp_error;
        int exp_eidx;
    } scen_t;

    tent_t tbl [NTBL];
    scen_t scen[5];
    xfer_t exp_q[$];
    int    m_done, m_err, m_eidx;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit nack_policy(input int mode, input int i, input int a, input int b);
        case (mode)
            1:       return (i == 1 && b == 3 && a < 2);
            2:       return (i == 3);
            3:       return ($urandom_range(0, 15) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Expected byte stream, per-byte gaps after the previous response, and final outcome.
    task automatic build_model(input int mode);
        int extra;
        bit fin;
        exp_q.delete();
        extra = 0; fin = 0; m_done = 0; m_err = 0; m_eidx = 0;
        for (int i = 0; i < NE && !fin; i++) begin
            if (i >= NTBL || tbl[i].op == 2) begin
                m_done = 1; fin = 1;
            end else if (tbl[i].op == 1) begin
                extra += ((tbl[i].data * DU > 0) ? tbl[i].data * DU : 1) + 1;
            end else begin
                bit ok = 0;
                for (int a = 0; a <= MR && !ok; a++) begin
                    bit nk = 0;
                    for (int b = 0; b < 4 && !nk; b++) begin
                        xfer_t x;
                        x.data  = (b == 0) ? 8'h76 : (b == 1) ? tbl[i].addr[15:8] :
                                  (b == 2) ? tbl[i].addr[7:0] : tbl[i].data;
                        x.st    = (b == 0);
                        x.sp    = (b == 3);
                        x.gap   = (b != 0) ? 1 : (a != 0) ? BO + 1 : 2 + extra;
                        x.entry = i;
                        nk      = nack_policy(mode, i, a, b);
                        x.nack  = nk;
                        exp_q.push_back(x);
                    end
                    if (!nk) ok = 1;
                end
                extra = 0;
                if (!ok) begin
                    m_err = 1; m_eidx = i; fin = 1;
                end
            end
        end
        if (!fin) m_done = 1;
    endtask

    task automatic run_agent(input int abort_entry, output bit aborted, output int k);
        int n, stall, lat, last_rsp;
        bit awaiting, in_xfer, pend_nack, prev_busy, prev_done, fin;
        logic [9:0] held, cur;
        aborted = 0; k = 0; n = 0; stall = 0; lat = 0; last_rsp = 0;
        awaiting = 0; in_xfer = 0; pend_nack = 0; fin = 0; held = '0;
        prev_busy = busy; prev_done = done;
        while (!fin && !aborted && n < BUDGET) begin
            @(negedge clk);
            n++;
            start = busy && ($urandom_range(0, 63) == 0);
            if (awaiting) begin
                if (lat == 0) begin
                    rsp_valid = 1'b1; rsp_nack = pend_nack; awaiting = 0; last_rsp = n;
                end else begin
                    rsp_valid = 1'b0; lat--;
                end
            end else begin
                rsp_valid = ($urandom_range(0, 7) == 0);
                rsp_nack  = 1'($urandom_range(0, 1));
            end
            cur = {cmd_start, cmd_stop, cmd_data};
            if (cmd_valid) begin
                if (!in_xfer) begin
                    if (k >= exp_q.size()) begin
                        chk("unexpected_extra_xfer", k, exp_q.size());
                        fin = 1;
                    end else begin
                        in_xfer = 1;
                        held    = cur;
                        chk($sformatf("xfer%0d_byte", k), cur, {exp_q[k].st, exp_q[k].sp, exp_q[k].data});
                        if (k > 0) chk($sformatf("xfer%0d_gap", k), n - last_rsp, exp_q[k].gap);
                        stall = $urandom_range(0, 5);
                        if (exp_q[k].entry == abort_entry) begin
                            rst_n = 1'b0;
                            #1;
                            chk("async_rst_cmd_valid", cmd_valid, 0);
                            chk("async_rst_busy", busy, 0);
                            chk("async_rst_cmd_start", cmd_start, 0);
                            aborted = 1;
                        end
                    end
                end else begin
                    chk($sformatf("xfer%0d_hold", k), cur, held);
                end
                if (in_xfer && !aborted) begin
                    if (stall == 0) begin
                        cmd_ready = 1'b1; awaiting = 1; lat = $urandom_range(0, 3);
                        pend_nack = exp_q[k].nack; in_xfer = 0; k++;
                    end else begin
                        cmd_ready = 1'b0; stall--;
                    end
                end
            end else begin
                cmd_ready = 1'b0;
            end
            if (done && !prev_done) chk("busy_falls_with_done", {prev_busy, busy}, 2'b10);
            prev_busy = busy;
            prev_done = done;
            if ((done || error) && !awaiting && k == exp_q.size()) fin = 1;
        end
        if (!fin && !aborted) chk("run_completed_in_budget", 0, 1);
        start = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b0;
    endtask

    task automatic run_scenario(input int mode, input int via_start, input int abort_entry,
                                input bit use_tab, input int td, input int te, input int tei);
        bit aborted;
        int k;
        int xd, xe, xi;
        build_model(mode);
        xd = use_tab ? td : m_done;
        xe = use_tab ? te : m_err;
        xi = use_tab ? tei : m_eidx;
        if (via_start == 0) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("started_busy", busy, 1);
        chk("started_done_clear", done, 0);
        chk("started_error_clear", error, 0);
        chk("started_err_index_clear", err_index, 0);
        run_agent(abort_entry, aborted, k);
        if (!aborted) begin
            chk("final_xfer_count", k, exp_q.size());
            chk("final_done", done, xd);
            chk("final_error", error, xe);
            chk("final_err_index", err_index, xi);
            chk("final_busy", busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
        tbl[0]  = '{0, 16'h4000, 8'h0F};
        tbl[1]  = '{0, 16'h4002, 8'h01};
        tbl[2]  = '{1, 16'h0000, 8'd10};
        tbl[3]  = '{0, 16'h4015, 8'h00};
        tbl[4]  = '{0, 16'h4019, 8'h03};
        tbl[5]  = '{0, 16'h401C, 8'h21};
        tbl[6]  = '{0, 16'h401E, 8'h41};
        tbl[7]  = '{0, 16'h4029, 8'h03};
        tbl[8]  = '{0, 16'h402A, 8'h03};
        tbl[9]  = '{0, 16'h40F2, 8'h01};
        tbl[10] = '{0, 16'h40F9, 8'h7F};
        tbl[11] = '{0, 16'h40FA, 8'h03};
        tbl[12] = '{2, 16'h0000, 8'h00};
        // mode, via_start, abort_entry, done, error, err_index
        scen[0] = '{0, 0, -1, 1, 0, 0};
        scen[1] = '{1, 1, -1, 1, 0, 0};
        scen[2] = '{2, 1, -1, 0, 1, 3};
        scen[3] = '{0, 1,  4, 0, 0, 0};
        scen[4] = '{0, 0, -1, 1, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_cmd_start", cmd_start, 0);
        chk("rst_cmd_stop", cmd_stop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_index", err_index, 0);

        for (int s = 0; s < 5; s++)
            run_scenario(scen[s].mode, scen[s].via_start, scen[s].abort_entry, 1'b1,
                         scen[s].exp_done, scen[s].exp_error, scen[s].exp_eidx);
        for (int r = 0; r < 4; r++)
            run_scenario(3, 1, -1, 1'b0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
